// File: rtl/tetris_pkg.sv
// Shared playfield geometry, score limit and row-clear state encoding.
// Used by the piece logic, the display scanner and the row-clear sequencer.
package tetris_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 6;
  localparam int SCORE_MAX = 9;

  localparam logic [COLS-1:0] FULL_ROW = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } clr_state_t;

endpackage

// File: rtl/row_clear_sequencer_sat_counter.sv
// 4-bit up-counter with synchronous clear that sticks at MAX.
// Clear has priority over increment.
module sat_counter #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_q
);

  logic [3:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q < MAX)) begin
      r_q <= r_q + 4'd1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/row_clear_sequencer.sv
// Sweeps the playfield bottom-up after a lock, collapsing each full row
// one row per cycle and counting cleared rows into a saturating score.
import tetris_pkg::*;

module row_clear_sequencer #(
  parameter int ROWS      = tetris_pkg::ROWS,
  parameter int COLS      = tetris_pkg::COLS,
  parameter int SCORE_MAX = tetris_pkg::SCORE_MAX
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            clear_score,
  output logic [2:0]      rd_addr,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [2:0]      wr_addr,
  output logic [COLS-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic [3:0]      score,
  output logic            overflow
);

  localparam logic [2:0] LAST = 3'(ROWS - 1);

  clr_state_t r_state;
  logic [2:0] r_r;
  logic [2:0] r_d;
  logic       r_busy;
  logic       r_done;
  logic       r_ovf;
  logic       w_full;
  logic       w_inc;

  assign w_full = &rd_data;
  assign w_inc  = (r_state == SCAN) && w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SCAN;
            r_r     <= LAST;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (w_full) begin
            r_d     <= r_r;
            r_state <= SHIFT;
          end else if (r_r == 3'd0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_r <= r_r - 3'd1;
          end
        end
        // r is left alone so the collapsed row gets rescanned
        SHIFT: begin
          if (r_d != 3'd0) begin
            r_d <= r_d - 3'd1;
          end else begin
            r_state <= SCAN;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_score) begin
      r_ovf <= 1'b0;
    end else if ((r_state == DONE) && (rd_data != '0)) begin
      r_ovf <= 1'b1;
    end
  end

  always_comb begin
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (r_state)
      SCAN: begin
        rd_addr = r_r;
      end
      SHIFT: begin
        wr_en   = 1'b1;
        wr_addr = r_d;
        if (r_d != 3'd0) begin
          rd_addr = r_d - 3'd1;
          wr_data = rd_data;
        end
      end
      default: begin
        rd_addr = '0;
      end
    endcase
  end

  sat_counter #(
    .MAX (4'(SCORE_MAX))
  ) u_score (
    .clk   (clk),
    .reset (reset),
    .i_clr (clear_score),
    .i_inc (w_inc),
    .o_q   (score)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_row_clear_sequencer.sv
// Bench for row_clear_sequencer: emulated playfield plus a board-level
// reference model of the clear/collapse rules.
module tb_row_clear_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear_score;
  logic [2:0] rd_addr;
  logic [5:0] rd_data;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic       busy;
  logic       done;
  logic [3:0] score;
  logic       overflow;

  logic [5:0] board [0:7];
  logic [5:0] img   [0:7];
  logic       ld;
  logic [5:0] mb    [0:5];

  int total = 0;
  int bad   = 0;
  int exp_score = 0;
  bit exp_ovf = 1'b0;
  int exp_lat = 0;

  int         wq_a [$];
  logic [5:0] wq_d [$];

  row_clear_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .clear_score (clear_score),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .score       (score),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  assign rd_data = board[rd_addr];

  always @(posedge clk) begin
    if (ld) begin
      for (int k = 0; k < 8; k++) board[k] <= img[k];
    end else if (wr_en) begin
      board[wr_addr] <= wr_data;
    end
  end

  // Reference: remove full rows bottom-up, dropping everything above.
  function automatic void model_sweep();
    int  r;
    bit  going;
    r = 5;
    going = 1'b1;
    exp_lat = 0;
    while (going) begin
      exp_lat++;
      if (mb[r] == 6'h3f) begin
        if (exp_score < 9) exp_score++;
        exp_lat += r + 1;
        for (int k = r; k > 0; k--) mb[k] = mb[k-1];
        mb[0] = 6'h00;
      end else if (r == 0) begin
        going = 1'b0;
      end else begin
        r--;
      end
    end
    exp_lat++;
    if (mb[0] != 6'h00) exp_ovf = 1'b1;
  endfunction

  function automatic logic [35:0] pack_dut();
    return {board[0], board[1], board[2], board[3], board[4], board[5]};
  endfunction

  function automatic logic [35:0] pack_mb();
    return {mb[0], mb[1], mb[2], mb[3], mb[4], mb[5]};
  endfunction

  task automatic load_board();
    for (int k = 0; k < 6; k++) img[k] = mb[k];
    img[6] = 6'h00;
    img[7] = 6'h00;
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic set_mb(input logic [35:0] v);
    for (int k = 0; k < 6; k++) mb[k] = v[35-6*k -: 6];
  endtask

  task automatic do_clear();
    @(negedge clk) clear_score = 1'b1;
    @(negedge clk) clear_score = 1'b0;
    exp_score = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic run_sweep(input int extra, output int lat,
                           output int done_at, output int nwr);
    int t;
    bit seen;
    lat = 0; done_at = 0; nwr = 0; seen = 1'b0; t = 0;
    wq_a.delete();
    wq_d.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (t < 200) begin
      if (busy) begin
        lat++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      if (done) done_at = lat;
      if (wr_en) begin
        nwr++;
        wq_a.push_back(int'(wr_addr));
        wq_d.push_back(wr_data);
      end
      start = (lat == extra);
      t++;
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (t >= 200) begin
      bad++;
      $display("FAIL sweep_timeout: busy=%0b after %0d cycles, required idle", busy, t);
    end
  endtask

  task automatic check_sweep(input string nm, input int lat, input int done_at);
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d required %0d", nm, lat, exp_lat);
    end
    total++;
    if (done_at !== exp_lat) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d required %0d", nm, done_at, exp_lat);
    end
    total++;
    if (pack_dut() !== pack_mb()) begin
      bad++;
      $display("FAIL %s board: got %h required %h", nm, pack_dut(), pack_mb());
    end
    total++;
    if (score !== 4'(exp_score)) begin
      bad++;
      $display("FAIL %s score: got %0d required %0d", nm, score, exp_score);
    end
    total++;
    if (overflow !== exp_ovf) begin
      bad++;
      $display("FAIL %s overflow: got %0b required %0b", nm, overflow, exp_ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    clear_score = 1'b0;
    ld = 1'b1;
    for (int k = 0; k < 8; k++) img[k] = 6'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ld = 1'b0;
    total++;
    if ({busy, done, wr_en, overflow, score} !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: busy/done/wr/ovf/score=%b required 0", {busy, done, wr_en, overflow, score});
    end
  endtask

  task automatic test_empty();
    int lat, da, nw;
    set_mb(36'h0);
    load_board();
    model_sweep();
    run_sweep(-1, lat, da, nw);
    check_sweep("empty", lat, da);
    total++;
    if (lat !== 7) begin
      bad++;
      $display("FAIL empty_busy7: got %0d required 7", lat);
    end
    total++;
    if (nw !== 0) begin
      bad++;
      $display("FAIL empty_writes: got %0d required 0", nw);
    end
  endtask

  task automatic test_row5();
    int lat, da, nw;
    do_clear();
    set_mb({6'h00, 6'h00, 6'h00, 6'h00, 6'h03, 6'h3f});
    load_board();
    model_sweep();
    run_sweep(-1, lat, da, nw);
    check_sweep("row5", lat, da);
    total++;
    if (nw !== 6) begin
      bad++;
      $display("FAIL row5_nwrites: got %0d required 6", nw);
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (wq_a[i] !== 5 - i || wq_d[i] !== ((i == 0) ? 6'h03 : 6'h00)) begin
          bad++;
          $display("FAIL row5_write%0d: got (%0d,%b) required (%0d,%b)", i, wq_a[i], wq_d[i], 5 - i, (i == 0) ? 6'h03 : 6'h00);
        end
      end
    end
    total++;
    if (lat !== 14 || score !== 4'd1) begin
      bad++;
      $display("FAIL row5_abs: lat=%0d score=%0d required 14/1", lat, score);
    end
  endtask

  task automatic test_two_rows();
    int lat, da, nw;
    do_clear();
    set_mb({6'h00, 6'h00, 6'h00, 6'h3f, 6'h21, 6'h3f});
    load_board();
    model_sweep();
    run_sweep(-1, lat, da, nw);
    check_sweep("two_rows", lat, da);
    total++;
    if (board[5] !== 6'h21 || score !== 4'd2) begin
      bad++;
      $display("FAIL two_rows_abs: row5=%b score=%0d required 100001/2", board[5], score);
    end
  endtask

  task automatic test_full_board();
    int lat, da, nw;
    do_clear();
    set_mb({36{1'b1}});
    load_board();
    model_sweep();
    run_sweep(-1, lat, da, nw);
    check_sweep("full_pre1", lat, da);
    set_mb({30'h0, 6'h3f});
    load_board();
    model_sweep();
    run_sweep(-1, lat, da, nw);
    check_sweep("full_pre2", lat, da);
    set_mb({36{1'b1}});
    load_board();
    model_sweep();
    run_sweep(-1, lat, da, nw);
    check_sweep("full_board", lat, da);
    total++;
    if (lat !== 49 || score !== 4'd9 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_abs: lat=%0d score=%0d ovf=%0b required 49/9/0", lat, score, overflow);
    end
  endtask

  task automatic test_overflow();
    int lat, da, nw;
    do_clear();
    set_mb({6'h0c, 30'h0});
    load_board();
    model_sweep();
    run_sweep(-1, lat, da, nw);
    check_sweep("overflow", lat, da);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: got %0b required 1", overflow);
    end
    do_clear();
    total++;
    if (overflow !== 1'b0 || score !== 4'd0) begin
      bad++;
      $display("FAIL overflow_clear: ovf=%0b score=%0d required 0/0", overflow, score);
    end
  endtask

  task automatic test_clear_wins();
    int lat, da, nw;
    do_clear();
    set_mb({30'h0, 6'h3f});
    load_board();
    model_sweep();
    clear_score = 1'b1;
    run_sweep(-1, lat, da, nw);
    clear_score = 1'b0;
    exp_score = 0;
    exp_ovf = 1'b0;
    check_sweep("clear_wins", lat, da);
  endtask

  task automatic test_random();
    int lat, da, nw;
    logic [5:0] row;
    do_clear();
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 6; k++) begin
        row = 6'($urandom);
        if ($urandom_range(0, 2) == 0) row = 6'h3f;
        if (k < 2 && $urandom_range(0, 3) != 0) row = 6'h00;
        mb[k] = row;
      end
      load_board();
      model_sweep();
      run_sweep(-1, lat, da, nw);
      check_sweep($sformatf("random%0d", it), lat, da);
      if ($urandom_range(0, 3) == 0) do_clear();
    end
  endtask

  task automatic test_back_to_back();
    int lat, da, nw, extra_busy;
    do_clear();
    set_mb(36'h0);
    load_board();
    model_sweep();
    run_sweep(3, lat, da, nw);
    check_sweep("b2b", lat, da);
    extra_busy = 0;
    repeat (6) begin
      if (busy) extra_busy++;
      @(negedge clk);
    end
    total++;
    if (extra_busy !== 0) begin
      bad++;
      $display("FAIL b2b_second_sweep: busy cycles=%0d required 0", extra_busy);
    end
  endtask

  task automatic test_reset_mid();
    int t, nbusy, nwr;
    do_clear();
    set_mb({6'h00, 6'h00, 6'h00, 6'h00, 6'h03, 6'h3f});
    load_board();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t = 0;
    while (!wr_en && t < 20) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 20) begin
      bad++;
      $display("FAIL reset_mid_no_shift: wr_en=%0b required 1", wr_en);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({busy, done, wr_en, overflow, score} !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_state: busy/done/wr/ovf/score=%b required 0", {busy, done, wr_en, overflow, score});
    end
    @(negedge clk) reset = 1'b0;
    nbusy = 0;
    nwr = 0;
    repeat (6) begin
      if (busy) nbusy++;
      if (wr_en) nwr++;
      @(negedge clk);
    end
    total++;
    if (nbusy !== 0 || nwr !== 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: busy=%0d writes=%0d required 0/0", nbusy, nwr);
    end
    set_mb({6'h00, 6'h00, 6'h00, 6'h00, 6'h03, 6'h03});
    total++;
    if (pack_dut() !== pack_mb()) begin
      bad++;
      $display("FAIL reset_mid_board: got %h required %h", pack_dut(), pack_mb());
    end
    exp_score = 0;
    exp_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_row5();
    test_two_rows();
    test_full_board();
    test_overflow();
    test_clear_wins();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
